// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB encodings and the AHB-to-APB bridge state type
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;

   localparam logic [2:0] HSIZE_WORD    = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WLATCH,
      ST_SETUP,
      ST_ACCESS,
      ST_DONE,
      ST_ERR1,
      ST_ERR2
   } bridge_state_e;

endpackage

// File: rtl/ahb2apb_bridge.sv
// rtl/ahb2apb_bridge.sv - AHB slave to APB master bridge, one APB transfer per AHB transfer
module ahb2apb_bridge
   import ahb_pkg::*;
#(
   parameter int          NSLV = 4,
   parameter logic [31:0] BASE = 32'h4000_0000
) (
   input  logic            HCLK,
   input  logic            HRESETn,
   input  logic            HSEL,
   input  logic [31:0]     HADDR,
   input  logic [1:0]      HTRANS,
   input  logic            HWRITE,
   input  logic [2:0]      HSIZE,
   input  logic [31:0]     HWDATA,
   input  logic            HREADY,
   output logic            HREADYOUT,
   output logic [31:0]     HRDATA,
   output logic [1:0]      HRESP,
   output logic [31:0]     PADDR,
   output logic [NSLV-1:0] PSEL,
   output logic            PENABLE,
   output logic            PWRITE,
   output logic [31:0]     PWDATA,
   input  logic [31:0]     PRDATA,
   input  logic            PREADY,
   input  logic            PSLVERR
);

   function automatic logic [NSLV-1:0] idx_decode(input logic [3:0] idx);
      logic [NSLV-1:0] sel;
      sel = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (idx == 4'(i)) sel[i] = 1'b1;
      end
      return sel;
   endfunction

   bridge_state_e   state_q, state_d;
   logic            hreadyout_q;
   logic [1:0]      hresp_q;
   logic [31:0]     hrdata_q;
   logic [31:0]     paddr_q;
   logic [NSLV-1:0] psel_q;
   logic            penable_q;
   logic            pwrite_q;
   logic [31:0]     pwdata_q;
   logic [3:0]      idx_q;

   logic [3:0]      hidx;
   logic [3:0]      sel_idx;
   logic            htrans_active;
   logic            accept;
   logic            legal;

   always_comb begin
      hidx          = HADDR[15:12];
      htrans_active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
      accept        = (state_q inside {ST_IDLE, ST_DONE, ST_ERR2}) && HSEL && HREADY && htrans_active;
      legal         = (int'(hidx) < NSLV) && (HSIZE == HSIZE_WORD) && (HADDR[31:16] == BASE[31:16]);
      // A read goes straight to SETUP, so the select must come from the live index.
      sel_idx       = (accept && legal) ? hidx : idx_q;

      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR2: begin
            if (accept) begin
               if (!legal)      state_d = ST_ERR1;
               else if (HWRITE) state_d = ST_WLATCH;
               else             state_d = ST_SETUP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WLATCH: state_d = ST_SETUP;
         ST_SETUP:  state_d = ST_ACCESS;
         ST_ACCESS: begin
            if (PREADY) state_d = PSLVERR ? ST_ERR1 : ST_DONE;
         end
         ST_ERR1:   state_d = ST_ERR2;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= ST_IDLE;
         hreadyout_q <= 1'b1;
         hresp_q     <= HRESP_OKAY;
         hrdata_q    <= '0;
         paddr_q     <= '0;
         psel_q      <= '0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         idx_q       <= '0;
      end else begin
         state_q     <= state_d;
         hreadyout_q <= state_d inside {ST_IDLE, ST_DONE, ST_ERR2};
         hresp_q     <= (state_d inside {ST_ERR1, ST_ERR2}) ? HRESP_ERROR : HRESP_OKAY;
         psel_q      <= (state_d inside {ST_SETUP, ST_ACCESS}) ? idx_decode(sel_idx) : '0;
         penable_q   <= (state_d == ST_ACCESS);
         if (accept && legal) begin
            paddr_q  <= HADDR;
            pwrite_q <= HWRITE;
            idx_q    <= hidx;
         end
         if (state_q == ST_WLATCH) pwdata_q <= HWDATA;
         if (state_q == ST_ACCESS && PREADY && !PSLVERR && !pwrite_q) hrdata_q <= PRDATA;
      end
   end

   assign HREADYOUT = hreadyout_q;
   assign HRESP     = hresp_q;
   assign HRDATA    = hrdata_q;
   assign PADDR     = paddr_q;
   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PWDATA    = pwdata_q;

endmodule

// File: doc/ahb2apb_bridge.md
AHB2APB_BRIDGE -- requirements
Module: ahb2apb_bridge

Interface
REQ-001 Parameter: NSLV, 4, number of APB peripherals; one-hot PSEL width; legal range 1..16.
REQ-002 Parameter: BASE, 32'h4000_0000, APB window base; peripheral index is HADDR[15:12].
REQ-003 HCLK  in  1  single clock; all state changes on rising edge.
REQ-004 HRESETn  in  1  reset; asynchronous, active-low.
REQ-005 HSEL  in  1  bridge selected by the AHB address decoder (its HSEL3 output).
REQ-006 HADDR  in  32  AHB address-phase address.
REQ-007 HTRANS  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
REQ-008 HWRITE  in  1  1 write, 0 read.
REQ-009 HSIZE  in  3  transfer size; only 3'b010 (32-bit) is legal.
REQ-010 HWDATA  in  32  write data, valid in the data phase.
REQ-011 HREADY  in  1  bus-wide ready; a transfer is accepted only when high.
REQ-012 HREADYOUT  out  1  bridge ready/wait-state output.
REQ-013 HRDATA  out  32  read data, registered.
REQ-014 HRESP  out  2  2'b00 OKAY, 2'b01 ERROR.
REQ-015 PADDR  out  32  APB address, registered.
REQ-016 PSEL  out  NSLV  one-hot APB peripheral select.
REQ-017 PENABLE  out  1  APB access-phase strobe.
REQ-018 PWRITE  out  1  APB direction.
REQ-019 PWDATA  out  32  APB write data, registered.
REQ-020 PRDATA  in  32  muxed APB read data.
REQ-021 PREADY  in  1  APB completion.
REQ-022 PSLVERR  in  1  APB error, sampled only when PENABLE and PREADY are both high.

Function
REQ-023 Accept condition: HSEL & HREADY & HTRANS[1] while the state is IDLE, DONE or ERR2; on accept, HADDR, HWRITE and the index are latched.
REQ-024 States: IDLE, WLATCH, SETUP, ACCESS, DONE, ERR1, ERR2.
REQ-025 Transitions on accept:
- Legal read -> SETUP.
- Legal write -> WLATCH.
- Index >= NSLV, HSIZE != 3'b010, or HADDR[31:16] != BASE[31:16] -> ERR1 with no APB activity.
REQ-026 WLATCH: PWDATA <= HWDATA; next state SETUP.
REQ-027 SETUP: PSEL[index]=1, PENABLE=0, PADDR and PWRITE stable; next state ACCESS.
REQ-028 ACCESS: PENABLE=1; hold while PREADY=0 (unbounded wait).
- PREADY & !PSLVERR -> DONE; HRDATA <= PRDATA on reads.
- PREADY & PSLVERR -> ERR1.
REQ-029 DONE: PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=OKAY; next state IDLE unless a new accept occurs.
REQ-030 ERR1: HREADYOUT=0, HRESP=ERROR. ERR2: HREADYOUT=1, HRESP=ERROR. ERR1 -> ERR2 -> IDLE (or an accepted transfer).
REQ-031 HREADYOUT=0 in WLATCH, SETUP, ACCESS and ERR1; 1 in IDLE, DONE and ERR2; registered, with no combinational path from PREADY.
REQ-032 Non-accepted cycles (IDLE/BUSY, HSEL=0 or HREADY=0) in IDLE give a zero-wait OKAY with no state change.
REQ-033 Latency with PREADY tied high: read data phase is 3 cycles (SETUP, ACCESS, DONE); write data phase is 4 cycles.
REQ-034 Back-to-back: an accept in DONE starts the next transfer with no IDLE cycle between.
REQ-035 HRDATA holds its value until the next successful read.

Reset
REQ-036 On HRESETn low, asynchronously: state=IDLE, HREADYOUT=1, HRESP=OKAY, HRDATA=0, PADDR=0, PSEL=0, PENABLE=0, PWRITE=0, PWDATA=0.
REQ-037 Reset mid-transfer aborts the transfer; PSEL and PENABLE drop in the same instant and no completion is reported.

Structure
REQ-038 Shared package ahb_pkg SHALL hold the HTRANS and HRESP encodings, the HSIZE word constant and the bridge state enum.
REQ-039 Single flat module with no sub-module; the index decode is an internal function.

Verification
REQ-040 Read, PREADY=1: HADDR=32'h4000_2004, PRDATA=32'hDEAD_BEEF -> PSEL=4'b0100, PADDR=32'h4000_2004, HREADYOUT low for 2 cycles, HRDATA=32'hDEAD_BEEF, HRESP OKAY.
REQ-041 Write with PREADY low for 3 ACCESS cycles: HADDR=32'h4000_1000, HWDATA=32'h1234_5678 -> PWDATA=32'h1234_5678 in SETUP, PENABLE high for 4 cycles, HREADYOUT low for 6 cycles.
REQ-042 PSLVERR=1 on a read to 32'h4000_3000 -> ERR1 (HREADYOUT=0, HRESP=01), then ERR2 (HREADYOUT=1, HRESP=01), then IDLE.
REQ-043 Unmapped HADDR=32'h4000_5000 or HSIZE=3'b000 -> two-cycle ERROR response and PSEL stays 0 throughout.
REQ-044 Back-to-back NONSEQ read then write, plus HRESETn pulsed during ACCESS of a third transfer -> second transfer starts in DONE; all outputs reach reset values without waiting for a clock edge.
